// File: rtl/cp0_exc_seq_pkg.sv
// Shared CP0 constants: register addresses, ExcCodes, Status bit indices
// and the exception sequencer state encoding.
package cp0_exc_seq_pkg;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;
  localparam int unsigned STATUS_BEV = 22;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_EPC    = 3'd1,
    ST_WR_CAUSE  = 3'd2,
    ST_WR_STATUS = 3'd3,
    ST_ER_STATUS = 3'd4,
    ST_REDIRECT  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/cp0_exc_seq_int_detect.sv
// Pending-interrupt detect: interrupts enabled, not already at exception
// level, and at least one unmasked pending line. Shared with ID hazard logic.
module cp0_int_detect (
  input  logic       ie,
  input  logic       exl,
  input  logic [7:0] im,
  input  logic [7:0] ip,
  output logic       int_pend
);

  assign int_pend = ie & ~exl & (|(im & ip));

endmodule

// File: rtl/cp0_exc_seq.sv
// CP0 exception/ERET sequencer: sole owner of the CP0 write port.
// Optional feature macro: CP0_BEV_VECTOR_EN (BEV selects bootstrap vector).
module cp0_exc_seq
  import cp0_exc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] BEV_VECTOR = 32'hBFC0_0380,
  parameter logic [4:0]  INT_CODE   = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_we_i,
  input  logic [4:0]  mtc0_addr_i,
  input  logic [31:0] mtc0_data_i,
  input  logic        exc_req_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_bd_i,
  input  logic        eret_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  seq_state_t  state_q, state_n;
  logic [4:0]  code_q, code_n;
  logic [31:0] pc_q, pc_n;
  logic        bd_q, bd_n;
  logic        we_n, flush_n;
  logic [4:0]  waddr_n;
  logic [31:0] wdata_n, new_pc_n;
  logic        int_pend;
  logic        bev_sel;
  logic [31:0] exc_vector;
  logic        unused_cause;

  cp0_int_detect u_int_detect (
    .ie       (status_i[STATUS_IE]),
    .exl      (status_i[STATUS_EXL]),
    .im       (status_i[15:8]),
    .ip       (cause_i[15:8]),
    .int_pend (int_pend)
  );

`ifdef CP0_BEV_VECTOR_EN
  assign bev_sel = status_i[STATUS_BEV];
`else
  assign bev_sel = 1'b0;
`endif
  assign exc_vector   = bev_sel ? BEV_VECTOR : EXC_VECTOR;
  assign unused_cause = ^{cause_i[31], cause_i[6:0]};

  assign busy_o = (state_q != ST_IDLE);

  // Output registers are loaded with the action of the state being entered,
  // so each write/flush is visible during the state that owns it.
  // Next-state decode and the registered CP0 port / redirect values.
  always_comb begin
    state_n  = state_q;
    code_n   = code_q;
    pc_n     = pc_q;
    bd_n     = bd_q;
    we_n     = 1'b0;
    waddr_n  = cp0_waddr_o;
    wdata_n  = cp0_wdata_o;
    flush_n  = 1'b0;
    new_pc_n = new_pc_o;
    unique case (state_q)
      ST_IDLE: begin
        if (int_pend || exc_req_i) begin
          code_n  = int_pend ? INT_CODE : exc_code_i;
          pc_n    = exc_pc_i;
          bd_n    = exc_bd_i;
          state_n = ST_WR_EPC;
          we_n    = ~status_i[STATUS_EXL];
          waddr_n = CP0_REG_EPC;
          wdata_n = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        end else if (eret_i) begin
          state_n = ST_ER_STATUS;
          we_n    = 1'b1;
          waddr_n = CP0_REG_STATUS;
          wdata_n = status_i & ~32'h2;
        end else if (mtc0_we_i) begin
          we_n    = 1'b1;
          waddr_n = mtc0_addr_i;
          wdata_n = mtc0_data_i;
        end
      end
      ST_WR_EPC: begin
        state_n = ST_WR_CAUSE;
        we_n    = 1'b1;
        waddr_n = CP0_REG_CAUSE;
        wdata_n = {bd_q, cause_i[30:7], code_q, 2'b00};
      end
      ST_WR_CAUSE: begin
        state_n = ST_WR_STATUS;
        we_n    = 1'b1;
        waddr_n = CP0_REG_STATUS;
        wdata_n = status_i | 32'h2;
      end
      ST_WR_STATUS: begin
        state_n  = ST_REDIRECT;
        flush_n  = 1'b1;
        new_pc_n = exc_vector;
      end
      ST_ER_STATUS: begin
        state_n  = ST_REDIRECT;
        flush_n  = 1'b1;
        new_pc_n = epc_i;
      end
      ST_REDIRECT: state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  // State, latched exception context and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      pc_q        <= '0;
      bd_q        <= 1'b0;
      cp0_we_o    <= 1'b0;
      cp0_waddr_o <= '0;
      cp0_wdata_o <= '0;
      flush_o     <= 1'b0;
      new_pc_o    <= '0;
    end else begin
      state_q     <= state_n;
      code_q      <= code_n;
      pc_q        <= pc_n;
      bd_q        <= bd_n;
      cp0_we_o    <= we_n;
      cp0_waddr_o <= waddr_n;
      cp0_wdata_o <= wdata_n;
      flush_o     <= flush_n;
      new_pc_o    <= new_pc_n;
    end
  end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Directed self-checking bench for cp0_exc_seq.
module tb_cp0_exc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        mtc0_we_i;
  logic [4:0]  mtc0_addr_i;
  logic [31:0] mtc0_data_i;
  logic        exc_req_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic        eret_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_vec;

  cp0_exc_seq #(
    .EXC_VECTOR (32'h0000_0020),
    .BEV_VECTOR (32'hBFC0_0380),
    .INT_CODE   (5'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mtc0_we_i   (mtc0_we_i),
    .mtc0_addr_i (mtc0_addr_i),
    .mtc0_data_i (mtc0_data_i),
    .exc_req_i   (exc_req_i),
    .exc_code_i  (exc_code_i),
    .exc_pc_i    (exc_pc_i),
    .exc_bd_i    (exc_bd_i),
    .eret_i      (eret_i),
    .status_i    (status_i),
    .cause_i     (cause_i),
    .epc_i       (epc_i),
    .cp0_we_o    (cp0_we_o),
    .cp0_waddr_o (cp0_waddr_o),
    .cp0_wdata_o (cp0_wdata_o),
    .flush_o     (flush_o),
    .new_pc_o    (new_pc_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write-port snapshot: we, waddr, wdata, flush, busy
  task automatic chk_wr(input string tag, input logic we, input logic [4:0] addr,
                        input logic [31:0] data);
    chk({tag, "_we"}, {31'd0, cp0_we_o}, {31'd0, we});
    if (we) begin
      chk({tag, "_addr"}, {27'd0, cp0_waddr_o}, {27'd0, addr});
      chk({tag, "_data"}, cp0_wdata_o, data);
    end
    chk({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
  endtask

  task automatic chk_flush(input string tag, input logic [31:0] pc);
    chk({tag, "_flush"}, {31'd0, flush_o}, 32'd1);
    chk({tag, "_newpc"}, new_pc_o, pc);
    chk({tag, "_we"}, {31'd0, cp0_we_o}, 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
    chk({tag, "_we"}, {31'd0, cp0_we_o}, 32'd0);
  endtask

  initial begin
`ifdef CP0_BEV_VECTOR_EN
    exp_vec = 32'hBFC0_0380;
`else
    exp_vec = 32'h0000_0020;
`endif
    rst = 1'b0; mtc0_we_i = 0; mtc0_addr_i = '0; mtc0_data_i = '0;
    exc_req_i = 0; exc_code_i = '0; exc_pc_i = '0; exc_bd_i = 0; eret_i = 0;
    status_i = '0; cause_i = '0; epc_i = '0;
    step(); step();
    chk("rst_we", {31'd0, cp0_we_o}, 32'd0);
    chk("rst_waddr", {27'd0, cp0_waddr_o}, 32'd0);
    chk("rst_wdata", cp0_wdata_o, 32'd0);
    chk("rst_newpc", new_pc_o, 32'd0);
    chk_idle("rst");
    rst = 1'b1;
    step();
    chk_idle("post_rst");

    // MTC0 pass-through, one cycle latency
    mtc0_we_i = 1; mtc0_addr_i = 5'd11; mtc0_data_i = 32'h100;
    step();
    mtc0_we_i = 0;
    chk("mtc0_we", {31'd0, cp0_we_o}, 32'd1);
    chk("mtc0_addr", {27'd0, cp0_waddr_o}, 32'd11);
    chk("mtc0_data", cp0_wdata_o, 32'h100);
    chk("mtc0_busy", {31'd0, busy_o}, 32'd0);
    step();
    chk("mtc0_off_we", {31'd0, cp0_we_o}, 32'd0);
    chk("mtc0_hold_addr", {27'd0, cp0_waddr_o}, 32'd11);
    chk("mtc0_hold_data", cp0_wdata_o, 32'h100);

    // Synchronous exception, Sys, EXL=0
    exc_req_i = 1; exc_code_i = 5'd8; exc_pc_i = 32'h40; exc_bd_i = 0;
    step();
    exc_req_i = 0;
    chk_wr("exc_epc", 1'b1, 5'd14, 32'h0000_0040);
    step();
    chk_wr("exc_cause", 1'b1, 5'd13, 32'h0000_0020);
    step();
    chk_wr("exc_status", 1'b1, 5'd12, 32'h0000_0002);
    step();
    chk_flush("exc", 32'h20);
    step();
    chk_idle("exc_done");

    // Delay slot with EXL already set: no EPC write, BD in Cause
    status_i = 32'h2; exc_req_i = 1; exc_code_i = 5'd10; exc_pc_i = 32'h80; exc_bd_i = 1;
    step();
    exc_req_i = 0;
    chk_wr("bd_epc", 1'b0, 5'd0, 32'h0);
    step();
    chk_wr("bd_cause", 1'b1, 5'd13, 32'h8000_0028);
    step();
    chk_wr("bd_status", 1'b1, 5'd12, 32'h0000_0002);
    step();
    chk_flush("bd", 32'h20);
    step();
    chk_idle("bd_done");

    // Interrupt wins over exception and a same-cycle MTC0
    status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
    exc_req_i = 1; exc_code_i = 5'd12; exc_pc_i = 32'h100; exc_bd_i = 0;
    mtc0_we_i = 1; mtc0_addr_i = 5'd9; mtc0_data_i = 32'hDEAD_BEEF;
    step();
    exc_req_i = 0; mtc0_we_i = 0;
    chk_wr("int_epc", 1'b1, 5'd14, 32'h0000_0100);
    step();
    chk_wr("int_cause", 1'b1, 5'd13, 32'h0000_0400);
    step();
    chk_wr("int_status", 1'b1, 5'd12, 32'h0000_0403);
    cause_i = 32'h0;
    step();
    chk_flush("int", 32'h20);
    step();
    chk_idle("int_done");

    // ERET
    status_i = 32'h3; epc_i = 32'h1234; eret_i = 1;
    step();
    eret_i = 0;
    chk_wr("eret_status", 1'b1, 5'd12, 32'h0000_0001);
    step();
    chk_flush("eret", 32'h1234);
    chk("eret_busy", {31'd0, busy_o}, 32'd1);
    step();
    chk_idle("eret_done");

    // Delay slot at pc=0 wraps; then async reset in WR_CAUSE
    status_i = 32'h0; exc_req_i = 1; exc_code_i = 5'd8; exc_pc_i = 32'h0; exc_bd_i = 1;
    step();
    exc_req_i = 0;
    chk_wr("wrap_epc", 1'b1, 5'd14, 32'hFFFF_FFFC);
    step();
    chk("wrap_cause_we", {31'd0, cp0_we_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_we", {31'd0, cp0_we_o}, 32'd0);
    chk("arst_wdata", cp0_wdata_o, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    step(); step();
    chk("arst_held_we", {31'd0, cp0_we_o}, 32'd0);
    rst = 1'b1;
    step(); step();
    chk_idle("arst_after");

    // Rerun with BEV set
    status_i = 32'h0040_0000; exc_req_i = 1; exc_code_i = 5'd8; exc_pc_i = 32'h44; exc_bd_i = 0;
    step();
    exc_req_i = 0;
    chk_wr("bev_epc", 1'b1, 5'd14, 32'h0000_0044);
    step();
    chk_wr("bev_cause", 1'b1, 5'd13, 32'h0000_0020);
    step();
    chk_wr("bev_status", 1'b1, 5'd12, 32'h0040_0002);
    step();
    chk_flush("bev", exp_vec);
    step();
    chk_idle("bev_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
